pe_dot_ctrl: RTL
================

Name: pe_dot_ctrl

Overview:
Operand-side driver for a single PE MAC core. Accepts a stream of (unsigned A, signed B) operand pairs grouped into vectors by a last flag, and issues one MAC pulse per pair with correct start/accumulate mode. It counts MAC completions, captures the 24-bit dot product when the vector finishes, and presents it on a valid/ready result port. It sits between the operand buffer/scheduler and the PE core.

Parameters:
MAX_TERMS, 256, maximum terms per vector; 256 × max |product| (32640) fits in 24-bit signed with no overflow.
CNT_W, 9, width of term counters; must satisfy 2^CNT_W > MAX_TERMS.

Ports:
clk  input  1  work clock
reset  input  1  synchronous reset, active-high
op_vld  input  1  operand pair valid
op_rdy  output  1  controller can accept operand pair
op_a  input  8  operand A, unsigned
op_b  input  8  operand B, signed
op_last  input  1  pair is final term of vector
abort  input  1  drop current vector, clear PE accumulator
pe_read_in  output  1  one-cycle MAC pulse to PE
pe_mode_sel  output  1  0 = first term (load), 1 = accumulate
pe_a_mul  output  8  operand A to PE
pe_b_mul  output  8  operand B to PE (signed)
pe_clr_acc  output  1  PE accumulator clear pulse
pe_out_vld  input  1  PE accumulator updated (one cycle after pe_read_in)
pe_pro_sum  input  24  PE accumulated value, signed
res_vld  output  1  result valid
res_rdy  input  1  result consumer ready
res_data  output  24  signed dot product
res_terms  output  CNT_W  number of terms in the result vector
err_len  output  1  sticky: vector hit MAX_TERMS without op_last

Behaviour:
- Reset is synchronous; all outputs 0; state IDLE; counters 0; err_len cleared only by reset.
- States: IDLE, RUN, DRAIN, HOLD.
- op_rdy = 1 in IDLE and RUN; 0 in DRAIN and HOLD. A pair is accepted on a cycle with op_vld && op_rdy && !abort.
- Accept at cycle t registers pe_read_in = 1, pe_a_mul = op_a, pe_b_mul = op_b at t+1. pe_read_in is high exactly one cycle per accepted pair. pe_a_mul and pe_b_mul hold their last value otherwise.
- pe_mode_sel at t+1 = 0 if the pair is the first of its vector, else 1.
- issued_cnt increments per accepted pair; done_cnt increments per pe_out_vld; both reset at vector start.
- IDLE -> RUN on an accepted pair without op_last. IDLE -> DRAIN on an accepted pair with op_last (single-term vector).
- RUN -> DRAIN on an accepted pair with op_last, or when issued_cnt reaches MAX_TERMS. In the second case, that pair is treated as the implicit last and err_len is set.
- In DRAIN, capture occurs in the cycle where pe_out_vld = 1 and done_cnt + 1 == issued_cnt. That cycle latches res_data <= pe_pro_sum and res_terms <= issued_cnt, then goes to HOLD.
- HOLD: res_vld = 1. res_data and res_terms are stable until res_rdy. On res_vld && res_rdy, go to IDLE; res_vld = 0 next cycle.
- Latency, 1-term vector: accept t, pe_read_in t+1, pe_out_vld t+2, res_vld t+3.
- Back-to-back accepts in RUN give one pe_read_in per cycle with no bubbles.
- pe_out_vld in IDLE or HOLD is ignored.
- abort (any state except IDLE) has priority over every other transition:
  - pe_clr_acc = 1 for one cycle (registered, cycle after abort);
  - pe_read_in is suppressed that cycle;
  - counters are cleared, res_vld = 0, state goes to IDLE, no result is produced.
- abort in IDLE still pulses pe_clr_acc. An op presented in the abort cycle is not accepted.
- pe_clr_acc is otherwise 0. The vector start uses pe_mode_sel = 0, not a clear.
- Reset mid-vector discards all state; no result is emitted.

Test Plan:
- 4-term vector (10,3),(255,-128),(0,5),(1,-1) with last on the 4th, res_rdy = 1:
  - pe_mode_sel sequence 0,1,1,1;
  - res_data = -32611 (0xFF809D), res_terms = 4.
- Single term (200,-1) with last, accepted at t:
  - pe_read_in at t+1;
  - res_vld at t+3, res_data = -200;
  - op_rdy = 0 from t+1 until the result handshake.
- Two back-to-back vectors {(2,2),(3,3)} and {(4,-4)}, res_rdy held 0 for 5 cycles:
  - res_data = 13 stays stable while res_rdy = 0;
  - no second vector is accepted until the handshake;
  - second result = -16 with pe_mode_sel = 0.
- op_vld gaps (valid every 3rd cycle) on a 3-term vector of (255,127):
  - pe_read_in pulses match the accepts one-to-one;
  - res_data = 97155.
- MAX_TERMS = 4, stream 6 pairs (1,1) without last:
  - err_len = 1;
  - result res_data = 4, res_terms = 4;
  - remaining pairs form the next vector.
- abort in RUN after 2 terms, then reset asserted mid-vector:
  - abort gives pe_clr_acc pulse, no res_vld, state IDLE;
  - reset gives all outputs 0 the following cycle.

Source files
------------

// File: rtl/pe_dot_ctrl.sv
// Operand-side driver for one PE MAC core. It streams (A, B) pairs into the MAC, counts completions
// and presents each finished dot product on a valid/ready result port.
module pe_dot_ctrl #(
    parameter int unsigned MAX_TERMS = 256,
    parameter int unsigned CNT_W     = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_vld,
    output logic             op_rdy,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    input  logic             op_last,
    input  logic             abort,
    output logic             pe_read_in,
    output logic             pe_mode_sel,
    output logic [7:0]       pe_a_mul,
    output logic [7:0]       pe_b_mul,
    output logic             pe_clr_acc,
    input  logic             pe_out_vld,
    input  logic [23:0]      pe_pro_sum,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [23:0]      res_data,
    output logic [CNT_W-1:0] res_terms,
    output logic             err_len
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StHold} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] issued_q, done_q;
    logic [CNT_W-1:0] issued_next, done_inc;
    logic             accept, limit_hit, vec_end, capture;

    logic             pe_read_in_q, pe_mode_sel_q, pe_clr_acc_q, err_len_q;
    logic [7:0]       pe_a_mul_q, pe_b_mul_q;
    logic [23:0]      res_data_q;
    logic [CNT_W-1:0] res_terms_q;

    assign accept      = op_vld && op_rdy && !abort;
    // The first pair of a vector restarts the count at one regardless of stale counter contents.
    assign issued_next = (state_q == StIdle) ? CntOne : issued_q + CntOne;
    assign limit_hit   = (issued_next == MaxCnt);
    assign vec_end     = accept && (op_last || limit_hit);
    assign done_inc    = done_q + CntOne;
    assign capture     = (state_q == StDrain) && pe_out_vld && (done_inc == issued_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (accept) state_d = vec_end ? StDrain : StRun;
                StRun:   if (vec_end) state_d = StDrain;
                StDrain: if (capture) state_d = StHold;
                StHold:  if (res_rdy) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Output logic
    always_comb begin
        op_rdy  = 1'b0;
        res_vld = 1'b0;
        unique case (state_q)
            StIdle:  op_rdy  = 1'b1;
            StRun:   op_rdy  = 1'b1;
            StDrain: op_rdy  = 1'b0;
            StHold:  res_vld = 1'b1;
            default: op_rdy  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            issued_q <= '0;
            done_q   <= '0;
        end else begin
            if (accept) begin
                issued_q <= issued_next;
            end
            if (accept && (state_q == StIdle)) begin
                done_q <= '0;
            end else if (pe_out_vld && (state_q == StRun || state_q == StDrain)) begin
                done_q <= done_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pe_read_in_q  <= 1'b0;
            pe_mode_sel_q <= 1'b0;
            pe_a_mul_q    <= '0;
            pe_b_mul_q    <= '0;
            pe_clr_acc_q  <= 1'b0;
            res_data_q    <= '0;
            res_terms_q   <= '0;
            err_len_q     <= 1'b0;
        end else begin
            pe_read_in_q <= accept;
            pe_clr_acc_q <= abort;
            if (accept) begin
                pe_a_mul_q    <= op_a;
                pe_b_mul_q    <= op_b;
                pe_mode_sel_q <= (state_q != StIdle);
            end
            if (capture && !abort) begin
                res_data_q  <= pe_pro_sum;
                res_terms_q <= issued_q;
            end
            // Length limit reached without a last flag: that pair closes the vector.
            if (accept && limit_hit && !op_last) begin
                err_len_q <= 1'b1;
            end
        end
    end

    assign pe_read_in  = pe_read_in_q;
    assign pe_mode_sel = pe_mode_sel_q;
    assign pe_a_mul    = pe_a_mul_q;
    assign pe_b_mul    = pe_b_mul_q;
    assign pe_clr_acc  = pe_clr_acc_q;
    assign res_data    = res_data_q;
    assign res_terms   = res_terms_q;
    assign err_len     = err_len_q;

endmodule
